// File: rtl/adc_capture_ctrl_if.sv
// ADC serial pins and FIFO write-side signals shared between the capture controller and
// its ADC/FIFO neighbours.
interface adc_capture_ctrl_if;
    logic        ad_sdata;
    logic        ad_cs_n;
    logic        ad_sclk;
    logic        fifo_full;
    logic        fifo_wrreq;
    logic [11:0] fifo_data;
    logic        fifo_clr;

    modport master (
        input  ad_sdata,
        input  fifo_full,
        output ad_cs_n,
        output ad_sclk,
        output fifo_wrreq,
        output fifo_data,
        output fifo_clr
    );

    modport slave (
        output ad_sdata,
        output fifo_full,
        input  ad_cs_n,
        input  ad_sclk,
        input  fifo_wrreq,
        input  fifo_data,
        input  fifo_clr
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Windowed capture from a serial 14-bit-frame ADC into the correlator sample FIFO.
// Every output is taken from a register that is loaded from next-state values.
module adc_capture_ctrl #(
    parameter int unsigned SCLK_HALF       = 2,
    parameter int unsigned QUIET_CYCLES    = 4,
    parameter int unsigned START_DELAY     = 0,
    parameter int unsigned CAPTURE_SAMPLES = 8000
) (
    input  logic                       clk_50M,
    input  logic                       rst_n,
    input  logic                       sys_start_pulse,
    adc_capture_ctrl_if.master         bus,
    output logic [15:0]                sample_cnt,
    output logic                       capture_busy,
    output logic                       capture_done,
    output logic                       overflow
);

    localparam logic [15:0] HalfLast   = 16'(SCLK_HALF - 1);
    localparam logic [15:0] ConvLast   = 16'(28 * SCLK_HALF - 1);
    localparam logic [15:0] QuietLast  = 16'(QUIET_CYCLES - 1);
    localparam logic [15:0] DelayLast  = 16'(START_DELAY);
    localparam logic [15:0] NumSamples = 16'(CAPTURE_SAMPLES);

    typedef enum logic [2:0] {StIdle, StDelay, StConv, StQuiet, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] half_q, half_d;
    logic [13:0] shift_q, shift_d;
    logic [11:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        wrreq_q, wrreq_d;
    logic        clr_q, clr_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            half_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            wrreq_q <= 1'b0;
            clr_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            half_q  <= half_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            wrreq_q <= wrreq_d;
            clr_q   <= clr_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        half_d  = half_q;
        shift_d = shift_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        sclk_d  = 1'b1;
        wrreq_d = 1'b0;
        clr_d   = 1'b0;
        ovf_d   = ovf_q;

        // A start always wins: any partial frame or pending write is abandoned.
        if (sys_start_pulse) begin
            state_d = StDelay;
            tmr_d   = '0;
            half_d  = '0;
            shift_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            clr_d   = 1'b1;
        end else begin
            unique case (state_q)
                StDelay: begin
                    if (tmr_q == DelayLast) begin
                        state_d = StConv;
                        tmr_d   = '0;
                        half_d  = '0;
                        sclk_d  = 1'b0;
                    end else begin
                        tmr_d = tmr_q + 16'd1;
                    end
                end
                StConv: begin
                    tmr_d  = tmr_q + 16'd1;
                    sclk_d = sclk_q;
                    if (half_q == HalfLast) begin
                        half_d = '0;
                        sclk_d = ~sclk_q;
                        if (!sclk_q) shift_d = {shift_q[12:0], bus.ad_sdata};
                    end else begin
                        half_d = half_q + 16'd1;
                    end
                    // The final high phase ends here; the shift register already holds the frame.
                    if (tmr_q == ConvLast) begin
                        state_d = StQuiet;
                        tmr_d   = '0;
                        sclk_d  = 1'b1;
                        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        if (bus.fifo_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            wrreq_d = 1'b1;
                            data_d  = shift_q[11:0];
                        end
                    end
                end
                StQuiet: begin
                    if (tmr_q == QuietLast) begin
                        tmr_d = '0;
                        if (cnt_q == NumSamples) begin
                            state_d = StDone;
                        end else begin
                            state_d = StConv;
                            half_d  = '0;
                            sclk_d  = 1'b0;
                        end
                    end else begin
                        tmr_d = tmr_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end

        cs_n_d = (state_d != StConv);
        busy_d = (state_d == StDelay) || (state_d == StConv) || (state_d == StQuiet);
        done_d = (state_d == StDone);
    end

    assign bus.ad_cs_n    = cs_n_q;
    assign bus.ad_sclk    = sclk_q;
    assign bus.fifo_wrreq = wrreq_q;
    assign bus.fifo_data  = data_q;
    assign bus.fifo_clr   = clr_q;
    assign sample_cnt     = cnt_q;
    assign capture_busy   = busy_q;
    assign capture_done   = done_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: a behavioural ADC feeds frames, a scoreboard checks FIFO writes,
// and window timing is measured in clock edges after the start pulse.
module tb_adc_capture_ctrl;

    logic        clk_50M = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [15:0] sample_cnt, sample_cnt2;
    logic        capture_busy, capture_busy2;
    logic        capture_done, capture_done2;
    logic        overflow, overflow2;

    int n_vec = 0;
    int n_err = 0;

    adc_capture_ctrl_if bus ();
    adc_capture_ctrl_if bus2 ();

    adc_capture_ctrl #(
        .CAPTURE_SAMPLES (4)
    ) u_dut (
        .clk_50M         (clk_50M),
        .rst_n           (rst_n),
        .sys_start_pulse (start),
        .bus             (bus),
        .sample_cnt      (sample_cnt),
        .capture_busy    (capture_busy),
        .capture_done    (capture_done),
        .overflow        (overflow)
    );

    adc_capture_ctrl #(
        .START_DELAY     (10),
        .CAPTURE_SAMPLES (4)
    ) u_dut_dly (
        .clk_50M         (clk_50M),
        .rst_n           (rst_n),
        .sys_start_pulse (start2),
        .bus             (bus2),
        .sample_cnt      (sample_cnt2),
        .capture_busy    (capture_busy2),
        .capture_done    (capture_done2),
        .overflow        (overflow2)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural ADC: next bit appears after each SCLK fall; expected sample queued once
    // the whole frame has been presented and the FIFO is accepting.
    logic [11:0] exp_q[$];
    logic [13:0] cur_frame;
    int          bit_idx   = 0;
    int          frame_idx = 0;
    logic        sclk_prev = 1'b1;

    always @(negedge clk_50M) begin
        if (bus.ad_cs_n) begin
            bit_idx = 0;
        end else if (!bus.ad_sclk && sclk_prev && bit_idx < 14) begin
            if (bit_idx == 0) begin
                cur_frame[13:12] = 2'(frame_idx);
                cur_frame[11:0]  = 12'hA5C ^ 12'(frame_idx * 37);
                frame_idx++;
            end
            bus.ad_sdata = cur_frame[13 - bit_idx];
            bit_idx++;
            if (bit_idx == 14 && !bus.fifo_full) exp_q.push_back(cur_frame[11:0]);
        end
        sclk_prev = bus.ad_sclk;
    end

    always @(negedge clk_50M) begin
        if (rst_n && bus.fifo_wrreq) begin
            if (exp_q.size() == 0) check_val("unexpected_wrreq", {20'd0, bus.fifo_data}, 32'hFFFF_FFFF);
            else check_val("fifo_data", {20'd0, bus.fifo_data}, {20'd0, exp_q.pop_front()});
        end
    end

    task automatic pulse_start();
        @(negedge clk_50M);
        start = 1'b1;
        @(posedge clk_50M);
        #1 start = 1'b0;
    endtask

    task automatic watch(input int ncyc, output int fall_k, output int done_k, output int nwr,
                         output int first_wr, output int bad_gap, output int low_after,
                         output int nclr);
        int last_wr;
        fall_k = -1; done_k = -1; nwr = 0; first_wr = -1;
        bad_gap = 0; low_after = 0; nclr = 0; last_wr = -1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk_50M);
            #1;
            if (fall_k < 0 && !bus.ad_cs_n) fall_k = k;
            if (done_k < 0 && capture_done) done_k = k;
            else if (done_k >= 0 && !bus.ad_cs_n) low_after++;
            if (bus.fifo_clr) nclr++;
            if (bus.fifo_wrreq) begin
                nwr++;
                if (first_wr < 0) first_wr = k;
                else if (k - last_wr != 60) bad_gap++;
                last_wr = k;
            end
        end
    endtask

    task automatic check_start_cycle();
        check_val("clr_after_start", {31'd0, bus.fifo_clr}, 32'd1);
        check_val("busy_after_start", {31'd0, capture_busy}, 32'd1);
        check_val("cs_n_after_start", {31'd0, bus.ad_cs_n}, 32'd1);
        check_val("sclk_after_start", {31'd0, bus.ad_sclk}, 32'd1);
        check_val("cnt_after_start", {16'd0, sample_cnt}, 32'd0);
        check_val("done_after_start", {31'd0, capture_done}, 32'd0);
    endtask

    initial begin
        int fall_k, done_k, nwr, first_wr, bad_gap, low_after, nclr, rises;
        logic sclk_last;

        rst_n          = 1'b0;
        start          = 1'b0;
        start2         = 1'b0;
        bus.ad_sdata   = 1'b0;
        bus.fifo_full  = 1'b0;
        bus2.ad_sdata  = 1'b0;
        bus2.fifo_full = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1 rst_n = 1'b1;
        @(posedge clk_50M);
        #1;
        check_val("rst_cs_n", {31'd0, bus.ad_cs_n}, 32'd1);
        check_val("rst_sclk", {31'd0, bus.ad_sclk}, 32'd1);
        check_val("rst_wrreq", {31'd0, bus.fifo_wrreq}, 32'd0);
        check_val("rst_clr", {31'd0, bus.fifo_clr}, 32'd0);
        check_val("rst_data", {20'd0, bus.fifo_data}, 32'd0);
        check_val("rst_cnt", {16'd0, sample_cnt}, 32'd0);
        check_val("rst_busy", {31'd0, capture_busy}, 32'd0);
        check_val("rst_done", {31'd0, capture_done}, 32'd0);
        check_val("rst_ovf", {31'd0, overflow}, 32'd0);

        // Full 4-sample window from idle.
        pulse_start();
        check_start_cycle();
        watch(441, fall_k, done_k, nwr, first_wr, bad_gap, low_after, nclr);
        check_val("w1_cs_fall", 32'(fall_k), 32'd1);
        check_val("w1_first_wr", 32'(first_wr), 32'd57);
        check_val("w1_nwr", 32'(nwr), 32'd4);
        check_val("w1_gap", 32'(bad_gap), 32'd0);
        check_val("w1_done_at", 32'(done_k), 32'd241);
        check_val("w1_cs_low_after_done", 32'(low_after), 32'd0);
        check_val("w1_extra_clr", 32'(nclr), 32'd0);
        check_val("w1_cnt", {16'd0, sample_cnt}, 32'd4);
        check_val("w1_done", {31'd0, capture_done}, 32'd1);
        check_val("w1_busy", {31'd0, capture_busy}, 32'd0);
        check_val("w1_ovf", {31'd0, overflow}, 32'd0);
        check_val("w1_sb_empty", 32'(exp_q.size()), 32'd0);

        // FIFO full across frame 2: that sample is dropped, timing unchanged.
        pulse_start();
        check_start_cycle();
        fork
            watch(441, fall_k, done_k, nwr, first_wr, bad_gap, low_after, nclr);
            begin
                repeat (70) @(posedge clk_50M);
                #2 bus.fifo_full = 1'b1;
                repeat (50) @(posedge clk_50M);
                #2 bus.fifo_full = 1'b0;
            end
        join
        check_val("w2_first_wr", 32'(first_wr), 32'd57);
        check_val("w2_nwr", 32'(nwr), 32'd3);
        check_val("w2_gap", 32'(bad_gap), 32'd1);
        check_val("w2_done_at", 32'(done_k), 32'd241);
        check_val("w2_cnt", {16'd0, sample_cnt}, 32'd4);
        check_val("w2_ovf", {31'd0, overflow}, 32'd1);
        check_val("w2_done", {31'd0, capture_done}, 32'd1);

        // Restart after the 7th SCLK rise of frame 2.
        pulse_start();
        check_val("w3_ovf_cleared", {31'd0, overflow}, 32'd0);
        rises     = 0;
        sclk_last = bus.ad_sclk;
        for (int i = 0; i < 200 && rises < 21; i++) begin
            @(posedge clk_50M);
            #1;
            if (!bus.ad_cs_n && bus.ad_sclk && !sclk_last) rises++;
            sclk_last = bus.ad_sclk;
        end
        check_val("w3_rises_reached", 32'(rises), 32'd21);
        check_val("w3_cnt_before_abort", {16'd0, sample_cnt}, 32'd1);
        pulse_start();
        check_start_cycle();
        watch(441, fall_k, done_k, nwr, first_wr, bad_gap, low_after, nclr);
        check_val("w3_cs_fall", 32'(fall_k), 32'd1);
        check_val("w3_first_wr", 32'(first_wr), 32'd57);
        check_val("w3_nwr", 32'(nwr), 32'd4);
        check_val("w3_done_at", 32'(done_k), 32'd241);
        check_val("w3_cnt", {16'd0, sample_cnt}, 32'd4);
        check_val("w3_sb_empty", 32'(exp_q.size()), 32'd0);

        // START_DELAY=10 instance.
        @(negedge clk_50M);
        start2 = 1'b1;
        @(posedge clk_50M);
        #1 start2 = 1'b0;
        check_val("dly_clr", {31'd0, bus2.fifo_clr}, 32'd1);
        fall_k = -1;
        nwr    = 0;
        for (int k = 0; k < 30 && fall_k < 0; k++) begin
            if (!capture_busy2) nwr++;
            if (!bus2.ad_cs_n) fall_k = k;
            if (fall_k < 0) begin
                @(posedge clk_50M);
                #1;
            end
        end
        check_val("dly_cs_fall", 32'(fall_k), 32'd11);
        check_val("dly_busy_gaps", 32'(nwr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
